// File: rtl/imem_pkg.sv
// Shared types and helpers for the instruction-RAM port arbiter.
// Holds the owner encoding, the fetch NOP value and the byte-address legality check.
package imem_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_LD   = 2'd2
    } owner_e;

    localparam logic [31:0] NOP_INSTR = 32'h0;

    // An address is illegal if it is not word aligned or its word index falls past the RAM
    function automatic logic addr_err(input logic [31:0] byte_addr, input logic [31:0] depth);
        return (byte_addr[1:0] != 2'b00) || ({2'b00, byte_addr[31:2]} >= depth);
    endfunction

endpackage

// File: rtl/imem_port_arbiter_if.sv
// Bundle of the fetch, loader and RAM-side signals around the arbiter.
// slave is the arbiter's view; master is the surrounding system (fetch, loader, RAM).
interface imem_port_arbiter_if #(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
);
    logic          cpu_req;
    logic [31:0]   cpu_addr;
    logic          cpu_stall;
    logic          cpu_valid;
    logic [31:0]   cpu_instr;
    logic          cpu_err;

    logic          ld_lock;
    logic          ld_req;
    logic          ld_we;
    logic [31:0]   ld_addr;
    logic [31:0]   ld_wdata;
    logic          ld_ack;
    logic [31:0]   ld_rdata;
    logic          ld_err;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    modport slave (
        input  cpu_req, cpu_addr, ld_lock, ld_req, ld_we, ld_addr, ld_wdata, mem_rdata,
        output cpu_stall, cpu_valid, cpu_instr, cpu_err, ld_ack, ld_rdata, ld_err,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output cpu_req, cpu_addr, ld_lock, ld_req, ld_we, ld_addr, ld_wdata, mem_rdata,
        input  cpu_stall, cpu_valid, cpu_instr, cpu_err, ld_ack, ld_rdata, ld_err,
               mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/imem_addr_check.sv
// Maps a byte address onto a RAM word index and flags misaligned or out-of-range accesses.
module imem_addr_check
    import imem_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic [31:0]   byte_addr,
    output logic [AW-1:0] word_idx,
    output logic          err
);

    assign word_idx = byte_addr[AW+1:2];
    assign err      = addr_err(byte_addr, 32'(DEPTH));

endmodule

// File: rtl/imem_port_arbiter.sv
// Shares a single-port synchronous instruction RAM between CPU fetch and the program loader.
// One access per cycle; the winner gets its response one cycle later, the loser is stalled.
module imem_port_arbiter
    import imem_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int LD_RUN = 4
) (
    input  logic                clk,
    input  logic                rst,
    imem_port_arbiter_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int RW = $clog2(LD_RUN + 1);
    localparam logic [RW-1:0] RUN_MAX = RW'(LD_RUN);

    logic [AW-1:0] cpu_idx;
    logic [AW-1:0] ld_idx;
    logic          cpu_aerr;
    logic          ld_aerr;

    logic          cpu_req_g;
    logic          ld_req_g;
    logic          ld_gnt;
    logic          cpu_gnt;

    owner_e        owner_d, owner_q;
    logic          err_d, err_q;
    logic          we_d, we_q;
    logic [RW-1:0] run_cnt_d, run_cnt_q;

    imem_addr_check #(.DEPTH(DEPTH), .AW(AW)) u_cpu_chk (
        .byte_addr (bus.cpu_addr),
        .word_idx  (cpu_idx),
        .err       (cpu_aerr)
    );

    imem_addr_check #(.DEPTH(DEPTH), .AW(AW)) u_ld_chk (
        .byte_addr (bus.ld_addr),
        .word_idx  (ld_idx),
        .err       (ld_aerr)
    );

    // Loader has priority until it has held the RAM LD_RUN times against a waiting fetch
    always_comb begin
        cpu_req_g = bus.cpu_req & ~rst;
        ld_req_g  = bus.ld_req & ~rst;
        ld_gnt    = ld_req_g & ((run_cnt_q < RUN_MAX) | ~cpu_req_g | bus.ld_lock);
        cpu_gnt   = ~ld_gnt & cpu_req_g & ~bus.ld_lock;

        owner_d = OWN_NONE;
        err_d   = 1'b0;
        we_d    = 1'b0;
        if (ld_gnt) begin
            owner_d = OWN_LD;
            err_d   = ld_aerr;
            we_d    = bus.ld_we;
        end else if (cpu_gnt) begin
            owner_d = OWN_CPU;
            err_d   = cpu_aerr;
        end

        run_cnt_d = run_cnt_q;
        if (cpu_gnt || !cpu_req_g) begin
            run_cnt_d = '0;
        end else if (ld_gnt && (run_cnt_q != RUN_MAX)) begin
            run_cnt_d = run_cnt_q + 1'b1;
        end
    end

    assign bus.mem_en    = (owner_d != OWN_NONE) & ~err_d;
    assign bus.mem_we    = ld_gnt & bus.ld_we & ~ld_aerr;
    assign bus.mem_addr  = ld_gnt ? ld_idx : cpu_idx;
    assign bus.mem_wdata = bus.ld_wdata;
    assign bus.cpu_stall = bus.cpu_req & ~cpu_gnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q   <= OWN_NONE;
            err_q     <= 1'b0;
            we_q      <= 1'b0;
            run_cnt_q <= '0;
        end else begin
            owner_q   <= owner_d;
            err_q     <= err_d;
            we_q      <= we_d;
            run_cnt_q <= run_cnt_d;
        end
    end

    // RAM read data lands in the cycle after the grant, so it is steered straight to the owner
    assign bus.cpu_valid = (owner_q == OWN_CPU);
    assign bus.cpu_err   = bus.cpu_valid & err_q;
    assign bus.cpu_instr = (bus.cpu_valid & ~err_q) ? bus.mem_rdata : NOP_INSTR;
    assign bus.ld_ack    = (owner_q == OWN_LD);
    assign bus.ld_err    = bus.ld_ack & err_q;
    assign bus.ld_rdata  = (bus.ld_ack & ~we_q & ~err_q) ? bus.mem_rdata : NOP_INSTR;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Bench for imem_port_arbiter: a vector table plus hand sequences, with a response scoreboard
// and a golden copy of RAM contents kept independently of the behavioural RAM beside the DUT.
module tb_imem_port_arbiter;
    import imem_pkg::*;

    localparam int DEPTH  = 64;
    localparam int LD_RUN = 4;

    typedef struct {
        logic        cpu_req;
        logic [31:0] cpu_addr;
        logic        ld_lock;
        logic        ld_req;
        logic        ld_we;
        logic [31:0] ld_addr;
        logic [31:0] ld_wdata;
        owner_e      exp_owner;
    } vec_t;

    typedef struct {
        owner_e      owner;
        logic        err;
        logic        we;
        logic [31:0] data;
    } resp_t;

    logic clk;
    logic rst;

    imem_port_arbiter_if #(.DEPTH(DEPTH)) bus ();

    imem_port_arbiter #(.DEPTH(DEPTH), .LD_RUN(LD_RUN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        return (i == 2) ? 32'h2005_0004 : (32'hA500_0000 | 32'(i));
    endfunction

    // Behavioural single-port synchronous RAM, reloaded whenever reset is seen on a clock edge
    logic [31:0] ram [DEPTH];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) ram[i] <= init_word(i);
            bus.mem_rdata <= 32'h0;
        end else if (bus.mem_en) begin
            if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata <= ram[bus.mem_addr];
        end
    end

    logic [31:0] golden [DEPTH];
    resp_t       sb [$];
    vec_t        vecs [16];
    int          n_checks;
    int          n_pass;
    int          stall_seen;

    function automatic logic tb_err(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a >= 32'(4 * DEPTH));
    endfunction

    function automatic vec_t mk(input logic cr, input logic [31:0] ca, input logic lk,
                                input logic lr, input logic lw, input logic [31:0] la,
                                input logic [31:0] wd, input owner_e o);
        vec_t v;
        v.cpu_req = cr; v.cpu_addr = ca; v.ld_lock = lk; v.ld_req = lr;
        v.ld_we = lw; v.ld_addr = la; v.ld_wdata = wd; v.exp_owner = o;
        return v;
    endfunction

    task automatic golden_init();
        for (int i = 0; i < DEPTH; i++) golden[i] = init_word(i);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: actual=%h required=%h", name, act, exp);
    endtask

    task automatic applyStimulus(input vec_t v);
        bus.cpu_req  = v.cpu_req;
        bus.cpu_addr = v.cpu_addr;
        bus.ld_lock  = v.ld_lock;
        bus.ld_req   = v.ld_req;
        bus.ld_we    = v.ld_we;
        bus.ld_addr  = v.ld_addr;
        bus.ld_wdata = v.ld_wdata;
    endtask

    // Compares the response due from last cycle's grant, then this cycle's RAM-side signals
    task automatic checkOutput(input vec_t v);
        resp_t       e;
        resp_t       n;
        logic        err_c;
        logic [31:0] a;
        if (sb.size() > 0) e = sb.pop_front();
        else e = '{owner: OWN_NONE, err: 1'b0, we: 1'b0, data: 32'h0};

        chk("cpu_valid", 32'(bus.cpu_valid), 32'(e.owner == OWN_CPU));
        chk("ld_ack",    32'(bus.ld_ack),    32'(e.owner == OWN_LD));
        chk("cpu_err",   32'(bus.cpu_err),   32'(e.owner == OWN_CPU && e.err));
        chk("ld_err",    32'(bus.ld_err),    32'(e.owner == OWN_LD && e.err));
        if (e.owner == OWN_CPU) chk("cpu_instr", bus.cpu_instr, e.data);
        if (e.owner == OWN_LD && !e.we && !e.err) chk("ld_rdata", bus.ld_rdata, e.data);

        a     = (v.exp_owner == OWN_LD) ? v.ld_addr : v.cpu_addr;
        err_c = (v.exp_owner != OWN_NONE) && tb_err(a);
        if (bus.cpu_stall) stall_seen++;
        chk("cpu_stall", 32'(bus.cpu_stall), 32'(v.cpu_req && v.exp_owner != OWN_CPU));
        chk("mem_en",    32'(bus.mem_en),    32'(v.exp_owner != OWN_NONE && !err_c));
        chk("mem_we",    32'(bus.mem_we),    32'(v.exp_owner == OWN_LD && v.ld_we && !err_c));
        if (v.exp_owner != OWN_NONE && !err_c) chk("mem_addr", 32'(bus.mem_addr), 32'(a[31:2]));
        if (v.exp_owner == OWN_LD && v.ld_we && !err_c) chk("mem_wdata", bus.mem_wdata, v.ld_wdata);

        n.owner = v.exp_owner;
        n.err   = err_c;
        n.we    = (v.exp_owner == OWN_LD) && v.ld_we;
        n.data  = (v.exp_owner == OWN_NONE || err_c) ? 32'h0 : golden[int'(a[31:2])];
        sb.push_back(n);
    endtask

    task automatic stepCycle(input vec_t v);
        applyStimulus(v);
        @(negedge clk);
        checkOutput(v);
        @(posedge clk);
        if (v.exp_owner == OWN_LD && v.ld_we && !tb_err(v.ld_addr))
            golden[int'(v.ld_addr[31:2])] = v.ld_wdata;
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_cpu_valid"}, 32'(bus.cpu_valid), 32'h0);
        chk({tag, "_ld_ack"},    32'(bus.ld_ack),    32'h0);
        chk({tag, "_cpu_err"},   32'(bus.cpu_err),   32'h0);
        chk({tag, "_ld_err"},    32'(bus.ld_err),    32'h0);
        chk({tag, "_mem_en"},    32'(bus.mem_en),    32'h0);
        chk({tag, "_mem_we"},    32'(bus.mem_we),    32'h0);
        chk({tag, "_cpu_instr"}, bus.cpu_instr,      32'h0);
        chk({tag, "_ld_rdata"},  bus.ld_rdata,       32'h0);
    endtask

    task automatic release_reset();
        applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, OWN_NONE));
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        golden_init();
    endtask

    vec_t idle;

    initial begin
        n_checks   = 0;
        n_pass     = 0;
        stall_seen = 0;
        idle       = mk(0, 0, 0, 0, 0, 0, 0, OWN_NONE);

        vecs[0]  = mk(1, 32'h08, 0, 0, 0, 32'h000, 32'h0,         OWN_CPU);
        vecs[1]  = idle;
        vecs[2]  = mk(0, 32'h00, 0, 1, 1, 32'h000, 32'h3c01_0000, OWN_LD);
        vecs[3]  = mk(0, 32'h00, 0, 1, 0, 32'h000, 32'h0,         OWN_LD);
        vecs[4]  = idle;
        vecs[5]  = mk(1, 32'h00, 0, 0, 0, 32'h000, 32'h0,         OWN_CPU);
        vecs[6]  = mk(1, 32'h06, 0, 0, 0, 32'h000, 32'h0,         OWN_CPU);
        vecs[7]  = mk(0, 32'h00, 0, 1, 1, 32'h100, 32'hDEAD_BEEF, OWN_LD);
        vecs[8]  = mk(1, 32'h10, 0, 1, 1, 32'h010, 32'h1122_3344, OWN_LD);
        vecs[9]  = mk(1, 32'h10, 0, 0, 0, 32'h000, 32'h0,         OWN_CPU);
        vecs[10] = mk(0, 32'h00, 0, 1, 0, 32'h002, 32'h0,         OWN_LD);
        vecs[11] = idle;
        vecs[12] = mk(1, 32'h04, 1, 1, 0, 32'h004, 32'h0,         OWN_LD);
        vecs[13] = mk(1, 32'h04, 1, 0, 0, 32'h000, 32'h0,         OWN_NONE);
        vecs[14] = mk(1, 32'h04, 0, 0, 0, 32'h000, 32'h0,         OWN_CPU);
        vecs[15] = idle;

        rst = 1'b1;
        applyStimulus(idle);
        golden_init();
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        foreach (vecs[i]) stepCycle(vecs[i]);

        // Both requesters held: four loader grants, then the fetch gets its turn
        stall_seen = 0;
        for (int i = 0; i < 10; i++)
            stepCycle(mk(1, 32'h24, 0, 1, 0, 32'h020, 32'h0, (i % 5 < 4) ? OWN_LD : OWN_CPU));
        chk("stall_4_of_5", 32'(stall_seen), 32'd8);
        stepCycle(idle);

        // Program mode shuts out fetch until the lock drops
        for (int i = 0; i < 10; i++) stepCycle(mk(1, 32'h08, 1, 0, 0, 0, 0, OWN_NONE));
        stepCycle(mk(1, 32'h08, 0, 0, 0, 0, 0, OWN_CPU));
        stepCycle(idle);

        // Lock raised right after a fetch was granted: that fetch still completes
        stepCycle(mk(1, 32'h08, 0, 0, 0, 0, 0, OWN_CPU));
        stepCycle(mk(0, 32'h00, 1, 0, 0, 0, 0, OWN_NONE));
        stepCycle(idle);

        // Reset raised in the grant cycle: nothing comes back
        applyStimulus(mk(1, 32'h08, 0, 1, 0, 32'h00C, 0, OWN_NONE));
        #1;
        rst = 1'b1;
        #1;
        chk("rst_grant_mem_en", 32'(bus.mem_en), 32'h0);
        @(posedge clk);
        #1;
        check_reset_outputs("rst_grant");
        release_reset();
        @(negedge clk);
        chk("post_rst_cpu_valid", 32'(bus.cpu_valid), 32'h0);
        chk("post_rst_ld_ack",    32'(bus.ld_ack),    32'h0);
        @(posedge clk);
        #1;

        // Reset raised while a response is outstanding drops it at once
        applyStimulus(mk(1, 32'h08, 0, 0, 0, 0, 0, OWN_CPU));
        @(posedge clk);
        #1;
        applyStimulus(idle);
        chk("pre_rst_cpu_valid", 32'(bus.cpu_valid), 32'h1);
        rst = 1'b1;
        #1;
        chk("mid_rst_cpu_valid", 32'(bus.cpu_valid), 32'h0);
        chk("mid_rst_cpu_instr", bus.cpu_instr,      32'h0);
        release_reset();

        stepCycle(mk(1, 32'h08, 0, 0, 0, 0, 0, OWN_CPU));
        stepCycle(idle);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
